// File: rtl/sram_rd_pipe_pkg.sv
// Shared defaults for the SRAM read-return pipeline.
// Holds data width, read latency and buffer depth.
package sram_rd_pipe_pkg;

  localparam int BIT_DATA  = 16;
  localparam int RD_LAT    = 1;
  localparam int BUF_DEPTH = 4;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small output FIFO for captured SRAM words.
// Full/empty come from the occupancy count.
module sram_rd_fifo
  import sram_rd_pipe_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clka) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/sram_rd_pipe.sv
// SRAM read-return pipe: latency tracking, credits,
// output FIFO and fill/hold output mux.
module sram_rd_pipe
  import sram_rd_pipe_pkg::*;
#(
  parameter int WIDTH  = BIT_DATA,
  parameter int LANES  = 4,
  parameter int RD_LAT = sram_rd_pipe_pkg::RD_LAT,
  parameter int DEPTH  = BUF_DEPTH
) (
  input  logic                       clka,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       wea,
  input  logic [LANES*WIDTH-1:0]     douta,
  input  logic                       hold_mode,
  input  logic                       out_ready,
  output logic                       rd_ready,
  output logic                       out_valid,
  output logic [LANES*WIDTH-1:0]     douta_buf,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int DW = LANES * WIDTH;
  localparam int SW = $clog2(DEPTH + RD_LAT + 1) + 1;

  logic [RD_LAT-1:0] vld;
  logic [DW-1:0]     last;
  logic [DW-1:0]     head;
  logic [SW-1:0]     credit;
  logic              strobe;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign strobe = vld[RD_LAT-1];
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  // A full FIFO still accepts a capture when it pops the same edge
  assign push = strobe & (~full | pop);

  always_ff @(posedge clka) begin
    if (rst) begin
      vld      <= '0;
      overflow <= 1'b0;
      last     <= '0;
    end else begin
      vld[0] <= ena & ~wea;
      for (int i = 1; i < RD_LAT; i++)
        vld[i] <= vld[i-1];
      if (strobe & full & ~pop)
        overflow <= 1'b1;
      if (pop)
        last <= head;
    end
  end

  always_comb begin
    credit = SW'(count);
    for (int i = 0; i < RD_LAT; i++)
      credit = credit + SW'(vld[i]);
  end

  assign rd_ready = (credit < SW'(DEPTH));

  always_comb begin
    douta_buf = '0;
    unique case (1'b1)
      out_valid:              douta_buf = head;
      (~out_valid & hold_mode): douta_buf = last;
      default:                douta_buf = '0;
    endcase
  end

  sram_rd_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clka  (clka),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (douta),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_sram_rd_pipe.sv
// Scoreboard bench for sram_rd_pipe with RD_LAT=2,
// DEPTH=4, four 16-bit lanes.
module tb_sram_rd_pipe;

  localparam int WIDTH  = 16;
  localparam int LANES  = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int DW     = WIDTH * LANES;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clka = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          wea = 1'b0;
  logic          hold_mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] douta = '0;
  logic          rd_ready;
  logic          out_valid;
  logic [DW-1:0] douta_buf;
  logic [CW-1:0] count;
  logic          overflow;

  sram_rd_pipe #(
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .RD_LAT (RD_LAT),
    .DEPTH  (DEPTH)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .ena       (ena),
    .wea       (wea),
    .douta     (douta),
    .hold_mode (hold_mode),
    .out_ready (out_ready),
    .rd_ready  (rd_ready),
    .out_valid (out_valid),
    .douta_buf (douta_buf),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clka = ~clka;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last = '0;
  int            pend[$];
  bit            m_ovf = 1'b0;
  int            edge_n = 0;
  bit            started = 1'b0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs and pops the scoreboard
  always @(negedge clka) begin
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("count", 64'(count), 64'(mq.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("rd_ready", 64'(rd_ready),
            64'((mq.size() + pend.size()) < DEPTH));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL head: got %h, expected no word at %0t",
                   douta_buf, $time);
        end else begin
          check("head", douta_buf, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("fill", douta_buf, hold_mode ? m_last : '0);
      end
    end
  end

  // Reference model: predicts the effect of the next rising edge
  always @(negedge clka) begin
    bit pop;
    #2;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      pend.delete();
      m_ovf = 1'b0;
      m_last = '0;
      started = 1'b1;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      if (pop) m_last = mq.pop_front();
      if (pend.size() > 0 && pend[0] == edge_n) begin
        void'(pend.pop_front());
        if (mq.size() == DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          mq.push_back(douta);
          exp_q.push_back(douta);
        end
      end
      if (ena && !wea) pend.push_back(edge_n + RD_LAT);
    end
    edge_n++;
  end

  task automatic step();
    @(posedge clka);
    #1;
    douta = {$urandom(), $urandom()};
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // single read, then pop with zero fill and hold
    ena = 1'b1;
    step();
    ena = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    hold_mode = 1'b1;
    step();
    hold_mode = 1'b0;
    step();

    // fill under credit control, no pops
    for (int i = 0; i < 8; i++) begin
      ena = rd_ready;
      step();
    end
    ena = 1'b0;
    repeat (3) step();

    // forced issue into a full FIFO
    ena = 1'b1;
    step();
    ena = 1'b0;
    repeat (3) step();

    // capture and pop on the same edge while full
    ena = 1'b1;
    step();
    ena = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (6) step();

    // writes interleaved with reads
    for (int i = 0; i < 6; i++) begin
      ena = 1'b1;
      wea = i[0];
      step();
    end
    ena = 1'b0;
    wea = 1'b0;
    repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(0, 3) != 0) &&
            (rd_ready || $urandom_range(0, 15) == 0);
      wea = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      hold_mode = $urandom_range(0, 1) == 1;
      step();
    end
    ena = 1'b0;
    wea = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    // reset with two reads in flight
    out_ready = 1'b0;
    ena = 1'b1;
    step();
    step();
    ena = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rd_pipe.md
Name: sram_rd_pipe

Overview:
- Parametrised successor to the single-word SRAM read capture register.
- Tracks issued reads (ena & ~wea) through a configurable SRAM read-latency delay line and captures LANES parallel words into a small output FIFO.
- Presents the FIFO head to the systolic array with valid/ready backpressure, plus a credit-based rd_ready so the SRAM controller never over-issues.
- Sits between the SRAM macro's douta and the PE row input.

Parameters:
- WIDTH, `BIT_DATA, bits per lane word
- LANES, 4, parallel words per SRAM read (douta is LANES*WIDTH bits)
- RD_LAT, 1, SRAM read latency in clka edges; legal range 1..4
- DEPTH, 4, output FIFO entries; power of 2, at least 2

Ports:
- clka  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  SRAM enable as driven to the macro
- wea  in  1  SRAM write enable; a read issue is ena & ~wea
- douta  in  LANES*WIDTH  SRAM read data; lane i is bits [i*WIDTH +: WIDTH]
- hold_mode  in  1  0: zero-fill output when empty; 1: hold last popped word
- out_ready  in  1  consumer accepts the head word
- rd_ready  out  1  credit available; controller may issue a read this cycle
- out_valid  out  1  FIFO head valid
- douta_buf  out  LANES*WIDTH  FIFO head, or fill value when out_valid=0
- count  out  $clog2(DEPTH+1)  occupied FIFO entries
- overflow  out  1  sticky; a returning read found the FIFO full

Behaviour:
- Reset values (rst=1 at an edge):
  - Valid delay line, FIFO pointers, count, overflow and the last-popped register all clear to 0.
  - In-flight reads are discarded.
  - After the reset edge: out_valid=0, douta_buf=0, count=0, overflow=0, rd_ready=1.
- Issue and capture timing:
  - An issue is sampled at edge k.
  - douta carries that read's data during the cycle ending at edge k+RD_LAT.
  - The data is written into the FIFO at edge k+RD_LAT.
  - out_valid is high immediately after that edge; issue to out_valid is RD_LAT edges.
- Delay line: RD_LAT-bit valid shift register. Bit 0 loads ena & ~wea; the last bit is the capture strobe.
  - Writes (wea=1) and idle cycles insert bubbles, which are never captured.
- Credits: inflight = popcount of the delay line.
  - rd_ready = (count + inflight) < DEPTH.
  - Combinational from registers only; no dependency on ena.
- Pop: out_valid & out_ready at an edge advances the read pointer and copies the head into the last-popped register.
- Capture when full:
  - If count==DEPTH and there is no pop at the same edge, the word is dropped and overflow is set.
  - overflow stays set until rst.
  - A pop and a capture at the same edge when full is legal: no drop, count unchanged.
- Simultaneous pop and capture in general: count unchanged; both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, not pointer equality.
- Output mux (combinational):
  - out_valid=1: douta_buf = head.
  - Otherwise: douta_buf = 0 if hold_mode=0, else the last-popped register.
  - hold_mode may change any cycle and takes effect the same cycle.
- Reset mid-operation: in-flight reads whose capture strobe would fall after the reset edge are never captured.

Decomposition:
- Add to param.v: `RD_LAT and `BUF_DEPTH default macros beside `BIT_DATA. No new typedefs.
- One sub-module: sram_rd_fifo. It holds the DEPTH x (LANES*WIDTH) storage, pointers and count, with push/pop/full/empty/head.
- The delay line, credit logic and output mux live in the top module.

Test Plan:
- Reset, then idle → out_valid=0, douta_buf=0, rd_ready=1, count=0.
- RD_LAT=2: issue at edge 3 with douta=0xA5A5_0001... during cycle 4–5 → captured at edge 5; out_valid=1 after edge 5, douta_buf equals that word. Then out_ready=1 pops at edge 6; hold_mode=0 gives douta_buf=0, hold_mode=1 gives the popped word.
- DEPTH=4, out_ready=0, issue every cycle while rd_ready → exactly 4 issues accepted; rd_ready falls after the 4th issue edge; count reaches 4; overflow stays 0.
- Force one extra issue while full with no pop → overflow=1 at its capture edge; count stays 4; the FIFO contents are unchanged.
- Full FIFO with out_ready=1 and a capture at the same edge → count stays 4; no overflow; the order of the next 4 pops matches the issue order.
- rst asserted while 2 reads are in flight → after reset, no capture occurs, count=0 and rd_ready=1.
